mem_seq_engine: RTL and testbench

- Command-driven sequencer directly upstream of the 8x32 behavioural word memory.
- Drives the memory's write_enable, address and data_in; consumes its asynchronous data_out.
- Executes one command at a time over a wrapping address range: FILL, SUM, MAX or COPY.
- Reports completion with a single-cycle done pulse and a result register.

---
 rtl/mem_seq_engine.sv | 195 +++++++++++++++++++
 tb/tb_mem_seq_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_engine.sv
// Command sequencer driving an 8x32 asynchronous-read word memory.
// Runs FILL, SUM, MAX or COPY over a wrapping address window and pulses done at completion.
module mem_seq_engine #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0] fill_value,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] OP_FILL = 2'b00;
   localparam logic [1:0] OP_SUM  = 2'b01;
   localparam logic [1:0] OP_COPY = 2'b11;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_SCAN  = 3'd2,
      S_CP_RD = 3'd3,
      S_CP_WR = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                state_q;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   idx_q;
   logic [DATA_WIDTH-1:0] fill_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [ADDR_WIDTH:0]   len_d;
   logic [ADDR_WIDTH:0]   idx_d;
   logic                  last_d;
   logic [ADDR_WIDTH-1:0] src_addr_d;
   logic [ADDR_WIDTH-1:0] dst_addr_d;
   logic [DATA_WIDTH-1:0] acc_d;

   always_comb begin
      len_d      = (length > DEPTH_L) ? DEPTH_L : length;
      idx_d      = idx_q + 1'b1;
      last_d     = (idx_d == len_q);
      src_addr_d = base_q + idx_d[ADDR_WIDTH-1:0];
      dst_addr_d = dst_q + idx_q[ADDR_WIDTH-1:0];
      if (op_q == OP_SUM)
         acc_d = acc_q + mem_rdata;
      else
         acc_d = (mem_rdata > acc_q) ? mem_rdata : acc_q;
   end

   // Memory-side outputs are registered one step ahead: each transition loads the
   // address/enable/data for the word the next state will touch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         base_q   <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         fill_q   <= '0;
         acc_q    <= '0;
         buf_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
               if (start) begin
                  op_q   <= op;
                  base_q <= base;
                  dst_q  <= dst;
                  len_q  <= len_d;
                  fill_q <= fill_value;
                  idx_q  <= '0;
                  acc_q  <= '0;
                  busy_q <= 1'b1;
                  if (len_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= base;
                     case (op)
                        OP_FILL: begin
                           state_q <= S_FILL;
                           we_q    <= 1'b1;
                           wdata_q <= fill_value;
                        end
                        OP_COPY: state_q <= S_CP_RD;
                        default: state_q <= S_SCAN;
                     endcase
                  end
               end
            end
            S_FILL: begin
               if (last_d) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  wdata_q <= '0;
               end else begin
                  idx_q   <= idx_d;
                  addr_q  <= src_addr_d;
                  wdata_q <= fill_q;
               end
            end
            S_SCAN: begin
               acc_q <= acc_d;
               if (last_d) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  result_q <= acc_d;
                  addr_q   <= '0;
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= src_addr_d;
               end
            end
            S_CP_RD: begin
               buf_q   <= mem_rdata;
               state_q <= S_CP_WR;
               we_q    <= 1'b1;
               addr_q  <= dst_addr_d;
               wdata_q <= mem_rdata;
            end
            S_CP_WR: begin
               we_q    <= 1'b0;
               wdata_q <= '0;
               if (last_d) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  addr_q  <= '0;
               end else begin
                  state_q <= S_CP_RD;
                  idx_q   <= idx_d;
                  addr_q  <= src_addr_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
            end
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign result           = result_q;
   assign mem_write_enable = we_q;
   assign mem_address      = addr_q;
   assign mem_wdata        = wdata_q;

endmodule

// File: tb/tb_mem_seq_engine.sv
// Directed bench for mem_seq_engine with an 8x32 asynchronous-read memory attached.
// Each comparison is an immediate assertion; a summary line closes the run.
module tb_mem_seq_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [2:0]  base = '0;
   logic [2:0]  dst = '0;
   logic [3:0]  length = '0;
   logic [31:0] fill_value = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        mem_write_enable;
   logic [2:0]  mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:7];
   logic [2:0]  wr_addr [0:31];
   int          wr_n = 0;
   logic        pl_en = 1'b0;
   logic [2:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   logic        clr_log = 1'b0;

   int compared = 0;
   int mismatched = 0;
   int lat;

   always #5 clk = ~clk;

   mem_seq_engine #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base(base), .dst(dst),
      .length(length), .fill_value(fill_value), .busy(busy), .done(done),
      .result(result), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_address];

   // Memory plus a write log; bench-side preload shares the same write port.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_write_enable) begin
         mem[mem_address] <= mem_wdata;
         wr_addr[wr_n[4:0]] <= mem_address;
         wr_n <= wr_n + 1;
      end
      if (clr_log) wr_n <= 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
      $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic poke(input logic [2:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic preload_seq(input logic [31:0] first, input logic [31:0] step);
      for (int i = 0; i < 8; i++) poke(3'(i), first + step * 32'(i));
   endtask

   task automatic run_cmd(input logic [1:0] o, input logic [2:0] b, input logic [2:0] d,
                          input logic [3:0] l, input logic [31:0] f, input bit glitch,
                          output int n);
      op = o; base = b; dst = d; length = l; fill_value = f;
      start = 1'b1; clr_log = 1'b1;
      tick();
      start = 1'b0; clr_log = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         if (glitch && n == 3) begin
            start = 1'b1; op = 2'b01; length = 4'd1; fill_value = 32'h99;
         end
         if (glitch && n == 5) start = 1'b0;
         tick();
         n++;
      end
   endtask

   task automatic end_cmd(input string tag);
      check({tag, "_busy_d"}, 64'(busy), 64'd1);
      tick();
      check({tag, "_done_pl"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_we", 64'(mem_write_enable), 64'd0);
      check("rst_addr", 64'(mem_address), 64'd0);
      check("rst_wdata", 64'(mem_wdata), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // FILL across the wrap point
      preload_seq(32'hC0DE_0000, 32'd1);
      run_cmd(2'b00, 3'd6, 3'd0, 4'd4, 32'hA5A5_0001, 1'b0, lat);
      check("fill_lat", 64'(lat), 64'd5);
      end_cmd("fill");
      check("fill_nwr", 64'(wr_n), 64'd4);
      check("fill_wa0", 64'(wr_addr[0]), 64'd6);
      check("fill_wa1", 64'(wr_addr[1]), 64'd7);
      check("fill_wa2", 64'(wr_addr[2]), 64'd0);
      check("fill_wa3", 64'(wr_addr[3]), 64'd1);
      check("fill_m6", 64'(mem[6]), 64'hA5A5_0001);
      check("fill_m1", 64'(mem[1]), 64'hA5A5_0001);
      check("fill_m2", 64'(mem[2]), 64'hC0DE_0002);
      check("fill_m5", 64'(mem[5]), 64'hC0DE_0005);
      check("fill_res", 64'(result), 64'd0);

      // SUM and MAX
      preload_seq(32'd1, 32'd1);
      run_cmd(2'b01, 3'd0, 3'd0, 4'd8, 32'd0, 1'b0, lat);
      check("sum_lat", 64'(lat), 64'd9);
      check("sum_res", 64'(result), 64'd36);
      end_cmd("sum");
      run_cmd(2'b10, 3'd2, 3'd0, 4'd3, 32'd0, 1'b0, lat);
      check("max_lat", 64'(lat), 64'd4);
      check("max_res", 64'(result), 64'd5);
      end_cmd("max");
      poke(3'd0, 32'h0000_0009);
      run_cmd(2'b10, 3'd7, 3'd0, 4'd3, 32'd0, 1'b0, lat);
      check("maxwrap_res", 64'(result), 64'd9);
      end_cmd("maxwrap");

      // SUM wraps mod 2**32
      poke(3'd0, 32'hFFFF_FFFF);
      poke(3'd1, 32'h0000_0002);
      run_cmd(2'b01, 3'd0, 3'd0, 4'd2, 32'd0, 1'b0, lat);
      check("wrap_res", 64'(result), 64'd1);
      end_cmd("wrap");

      // COPY with overlapping forward range, then a disjoint wrap-around copy
      preload_seq(32'h10, 32'd1);
      run_cmd(2'b11, 3'd0, 3'd1, 4'd3, 32'd0, 1'b0, lat);
      check("cp1_lat", 64'(lat), 64'd7);
      end_cmd("cp1");
      check("cp1_nwr", 64'(wr_n), 64'd3);
      check("cp1_m1", 64'(mem[1]), 64'h10);
      check("cp1_m2", 64'(mem[2]), 64'h10);
      check("cp1_m3", 64'(mem[3]), 64'h10);
      check("cp1_m4", 64'(mem[4]), 64'h14);
      check("cp1_res", 64'(result), 64'd1);
      run_cmd(2'b11, 3'd4, 3'd0, 4'd2, 32'd0, 1'b0, lat);
      check("cp2_lat", 64'(lat), 64'd5);
      end_cmd("cp2");
      check("cp2_m0", 64'(mem[0]), 64'h14);
      check("cp2_m1", 64'(mem[1]), 64'h15);

      // length 0: immediate done, no access, result held
      run_cmd(2'b01, 3'd0, 3'd0, 4'd0, 32'd0, 1'b0, lat);
      check("z_sum_lat", 64'(lat), 64'd1);
      check("z_sum_res", 64'(result), 64'd1);
      end_cmd("zsum");
      check("z_sum_nwr", 64'(wr_n), 64'd0);
      run_cmd(2'b00, 3'd0, 3'd0, 4'd0, 32'hDEAD, 1'b0, lat);
      check("z_fill_lat", 64'(lat), 64'd1);
      end_cmd("zfill");
      check("z_fill_nwr", 64'(wr_n), 64'd0);
      check("z_fill_m0", 64'(mem[0]), 64'h14);

      // length 12 clamps to 8; start while busy ignored
      run_cmd(2'b00, 3'd3, 3'd0, 4'd12, 32'h77, 1'b1, lat);
      check("clamp_lat", 64'(lat), 64'd9);
      end_cmd("clamp");
      check("clamp_nwr", 64'(wr_n), 64'd8);
      check("clamp_m2", 64'(mem[2]), 64'h77);
      check("clamp_m3", 64'(mem[3]), 64'h77);
      check("clamp_res", 64'(result), 64'd1);

      // reset in the middle of an 8-word FILL
      preload_seq(32'd0, 32'd0);
      op = 2'b00; base = 3'd0; length = 4'd8; fill_value = 32'h5555;
      start = 1'b1; clr_log = 1'b1;
      tick();
      start = 1'b0; clr_log = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("ar_we", 64'(mem_write_enable), 64'd0);
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_res", 64'(result), 64'd0);
      check("ar_addr", 64'(mem_address), 64'd0);
      check("ar_nwr_pre", 64'(wr_n), 64'd2);
      clr_log = 1'b1;
      tick();
      clr_log = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("ar_nwr", 64'(wr_n), 64'd0);
      check("ar_idle", 64'(busy), 64'd0);
      check("ar_m0", 64'(mem[0]), 64'h5555);
      check("ar_m2", 64'(mem[2]), 64'd0);

      // fresh commands after reset
      run_cmd(2'b00, 3'd2, 3'd0, 4'd2, 32'hBEEF, 1'b0, lat);
      check("post_lat", 64'(lat), 64'd3);
      end_cmd("post");
      check("post_m2", 64'(mem[2]), 64'hBEEF);
      check("post_m3", 64'(mem[3]), 64'hBEEF);
      check("post_m4", 64'(mem[4]), 64'd0);
      run_cmd(2'b01, 3'd0, 3'd0, 4'd3, 32'd0, 1'b0, lat);
      check("post_sum", 64'(result), 64'h0001_6999);
      end_cmd("psum");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
